// File: rtl/ioctl_upload_reader.sv
// ioctl upload reader: streams SDRAM back to the HPS over the ioctl upload channel.
// It turns 16-bit HPS halfword reads into 32-bit Wishbone classic reads.
// A one-word cache lets the second halfword of a word be served without a bus cycle.
module ioctl_upload_reader #(
    parameter logic [25:0] BASE_ADDR = 26'h0400000,
    parameter int          TIMEOUT   = 1023
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [15:0] ioctl_din,
    output logic        ioctl_wait,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [3:0]  wb_sel,
    output logic [2:0]  wb_cti,
    output logic [25:0] wb_adr,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack,
    output logic        rd_error
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, FETCH, ABORT} state_t;

    state_t        state_q;
    state_t        state_d;
    logic          upload_q;
    logic [31:0]   cache_word;
    logic [22:0]   cache_tag;
    logic          cache_valid;
    logic [22:0]   req_tag;
    logic          req_half;
    logic          deliver;
    logic [CW-1:0] count_q;

    logic          upload_rise;
    logic          cache_hit;
    logic          start_hit;
    logic          start_miss;
    logic          fetch_done;
    logic          fetch_timeout;
    logic          fetch_abort;
    logic          unused_addr_bit;

    assign upload_rise     = ioctl_upload && !upload_q;
    assign cache_hit       = cache_valid && !upload_rise && (cache_tag == ioctl_addr[24:2]);
    assign unused_addr_bit = ioctl_addr[0];

    assign wb_stb = wb_cyc;
    assign wb_we  = 1'b0;
    assign wb_sel = 4'b1111;
    assign wb_cti = 3'b000;

    // State register for the read sequencer.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: accept reads only when idle and not holding off the HPS.
    always_comb begin
        state_d       = state_q;
        start_hit     = 1'b0;
        start_miss    = 1'b0;
        fetch_done    = 1'b0;
        fetch_timeout = 1'b0;
        fetch_abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ioctl_rd && ioctl_upload && !ioctl_wait) begin
                    if (cache_hit) begin
                        start_hit = 1'b1;
                    end else begin
                        start_miss = 1'b1;
                        state_d    = FETCH;
                    end
                end
            end
            FETCH: begin
                if (!ioctl_upload) begin
                    fetch_abort = 1'b1;
                    state_d     = ABORT;
                end else if (wb_ack) begin
                    fetch_done = 1'b1;
                    state_d    = IDLE;
                end else if (count_q == COUNT_LAST) begin
                    fetch_timeout = 1'b1;
                    state_d       = IDLE;
                end
            end
            ABORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: bus control, cache, returned halfword, timeout counter and error flag.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            upload_q    <= 1'b0;
            cache_word  <= 32'h0;
            cache_tag   <= 23'h0;
            cache_valid <= 1'b0;
            req_tag     <= 23'h0;
            req_half    <= 1'b0;
            deliver     <= 1'b0;
            count_q     <= '0;
            wb_cyc      <= 1'b0;
            wb_adr      <= 26'h0;
            ioctl_din   <= 16'h0;
            ioctl_wait  <= 1'b0;
            rd_error    <= 1'b0;
        end else begin
            upload_q <= ioctl_upload;
            deliver  <= fetch_done;

            if (upload_rise) begin
                cache_valid <= 1'b0;
                rd_error    <= 1'b0;
            end

            if (deliver) begin
                ioctl_din  <= req_half ? cache_word[31:16] : cache_word[15:0];
                ioctl_wait <= 1'b0;
            end

            if (start_hit) begin
                ioctl_din <= ioctl_addr[1] ? cache_word[31:16] : cache_word[15:0];
            end

            if (start_miss) begin
                wb_adr     <= BASE_ADDR + {1'b0, ioctl_addr[24:2], 2'b00};
                req_tag    <= ioctl_addr[24:2];
                req_half   <= ioctl_addr[1];
                wb_cyc     <= 1'b1;
                ioctl_wait <= 1'b1;
                count_q    <= '0;
            end

            if (state_q == FETCH) begin
                count_q <= count_q + CW'(1);
            end

            if (fetch_done) begin
                cache_word  <= wb_dat_i;
                cache_tag   <= req_tag;
                cache_valid <= 1'b1;
                wb_cyc      <= 1'b0;
            end

            if (fetch_timeout) begin
                wb_cyc      <= 1'b0;
                ioctl_din   <= 16'hFFFF;
                rd_error    <= 1'b1;
                cache_valid <= 1'b0;
                ioctl_wait  <= 1'b0;
            end

            if (fetch_abort) begin
                wb_cyc     <= 1'b0;
                ioctl_wait <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Testbench for ioctl_upload_reader: a Wishbone SDRAM responder plus a word-level
// reference model of the HPS-visible behaviour, with directed and random reads.
module tb_ioctl_upload_reader;

    localparam int          TO   = 15;
    localparam logic [25:0] BASE = 26'h0400000;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [15:0] ioctl_din;
    logic        ioctl_wait;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [2:0]  wb_cti;
    logic [25:0] wb_adr;
    logic [31:0] wb_dat_i = 32'h0;
    logic        wb_ack = 1'b0;
    logic        rd_error;

    int pass_count = 0;
    int check_count = 0;

    // SDRAM contents, filled lazily with random words
    logic [31:0] sdram [logic [25:0]];

    // Responder configuration
    int ack_latency = 0;
    int late_ack_delay = 0;
    int cyc_seen = 0;

    // Reference model state
    logic        m_valid = 1'b0;
    logic [22:0] m_tag = 23'h0;
    logic        m_err = 1'b0;
    logic [15:0] m_din = 16'h0;

    always #5 clk_sys = ~clk_sys;

    ioctl_upload_reader #(
        .BASE_ADDR(BASE),
        .TIMEOUT  (TO)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ioctl_upload(ioctl_upload),
        .ioctl_rd    (ioctl_rd),
        .ioctl_addr  (ioctl_addr),
        .ioctl_din   (ioctl_din),
        .ioctl_wait  (ioctl_wait),
        .wb_cyc      (wb_cyc),
        .wb_stb      (wb_stb),
        .wb_we       (wb_we),
        .wb_sel      (wb_sel),
        .wb_cti      (wb_cti),
        .wb_adr      (wb_adr),
        .wb_dat_i    (wb_dat_i),
        .wb_ack      (wb_ack),
        .rd_error    (rd_error)
    );

    function automatic logic [31:0] memWord(input logic [25:0] adr);
        if (!sdram.exists(adr)) sdram[adr] = $urandom;
        return sdram[adr];
    endfunction

    // Wishbone responder: acks after ack_latency cycles of wb_cyc, or a stray late ack
    always begin
        @(posedge clk_sys);
        #2;
        wb_ack = 1'b0;
        if (wb_cyc) begin
            cyc_seen++;
            if (ack_latency > 0 && cyc_seen == ack_latency) begin
                wb_ack   = 1'b1;
                wb_dat_i = memWord(wb_adr);
            end
        end else begin
            cyc_seen = 0;
        end
        if (late_ack_delay > 0) begin
            late_ack_delay--;
            if (late_ack_delay == 0) begin
                wb_ack   = 1'b1;
                wb_dat_i = 32'hDEADBEEF;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic [24:0] addr);
        @(negedge clk_sys);
        ioctl_rd   = rd;
        ioctl_addr = addr;
    endtask

    task automatic setUpload(input logic v);
        @(negedge clk_sys);
        if (v && !ioctl_upload) begin
            m_valid = 1'b0;
            m_err   = 1'b0;
        end
        ioctl_upload = v;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cyc"}, {31'h0, wb_cyc}, 32'h0);
        checkOutput({tag, "_stb"}, {31'h0, wb_stb}, 32'h0);
        checkOutput({tag, "_wait"}, {31'h0, ioctl_wait}, 32'h0);
        checkOutput({tag, "_din"}, {16'h0, ioctl_din}, 32'h0);
        checkOutput({tag, "_err"}, {31'h0, rd_error}, 32'h0);
    endtask

    // One halfword read; lat = 0 means the SDRAM never acknowledges
    task automatic readHalf(input string tag, input logic [24:0] addr, input int lat);
        logic [25:0] exp_adr;
        logic [31:0] word;
        logic [15:0] half;
        logic        hit;
        int          exp_wait;
        int          exp_cyc;
        int          wait_cycles;
        int          cyc_cycles;
        int          stb_bad;
        logic [25:0] adr_seen;

        exp_adr = BASE + {1'b0, addr[24:2], 2'b00};
        word    = memWord(exp_adr);
        half    = addr[1] ? word[31:16] : word[15:0];
        hit     = m_valid && (m_tag == addr[24:2]);

        if (hit) begin
            exp_wait = 0;
            exp_cyc  = 0;
            m_din    = half;
        end else if (lat == 0) begin
            exp_wait = TO;
            exp_cyc  = TO;
            m_din    = 16'hFFFF;
            m_err    = 1'b1;
            m_valid  = 1'b0;
        end else begin
            exp_wait = lat + 1;
            exp_cyc  = lat;
            m_din    = half;
            m_valid  = 1'b1;
            m_tag    = addr[24:2];
        end

        ack_latency = lat;
        applyStimulus(1'b1, addr);
        applyStimulus(1'b0, 25'($urandom));

        wait_cycles = 0;
        cyc_cycles  = 0;
        stb_bad     = 0;
        adr_seen    = 26'h0;
        for (int i = 0; i < 100 && ioctl_wait; i++) begin
            wait_cycles++;
            if (wb_cyc) begin
                cyc_cycles++;
                adr_seen = wb_adr;
            end
            if (wb_stb !== wb_cyc || wb_we !== 1'b0 || wb_sel !== 4'hF || wb_cti !== 3'h0) stb_bad++;
            @(negedge clk_sys);
        end

        checkOutput({tag, "_wait_cycles"}, wait_cycles, exp_wait);
        checkOutput({tag, "_cyc_cycles"}, cyc_cycles, exp_cyc);
        if (!hit) checkOutput({tag, "_adr"}, {6'h0, adr_seen}, {6'h0, exp_adr});
        checkOutput({tag, "_din"}, {16'h0, ioctl_din}, {16'h0, m_din});
        checkOutput({tag, "_err"}, {31'h0, rd_error}, {31'h0, m_err});
        checkOutput({tag, "_cyc_after"}, {31'h0, wb_cyc}, 32'h0);
        checkOutput({tag, "_bus_ctrl"}, stb_bad, 0);
    endtask

    initial begin
        logic [24:0] addr;
        reset_n      = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = 25'h0;
        sdram[26'h0400000] = 32'h1234ABCD;

        repeat (2) @(negedge clk_sys);
        checkResetValues("reset");
        reset_n = 1'b1;
        @(negedge clk_sys);
        checkResetValues("post_reset");

        setUpload(1'b1);
        readHalf("t1_miss_addr0", 25'h0, 5);
        readHalf("t2_hit_addr2", 25'h2, 3);
        readHalf("t3_miss_addr4", 25'h4, 3);
        readHalf("t3_miss_addr0", 25'h0, 2);

        // Reads outside the upload window are ignored
        setUpload(1'b0);
        applyStimulus(1'b1, 25'h10);
        applyStimulus(1'b0, 25'h0);
        repeat (2) @(negedge clk_sys);
        checkOutput("no_upload_cyc", {31'h0, wb_cyc}, 32'h0);
        checkOutput("no_upload_wait", {31'h0, ioctl_wait}, 32'h0);
        checkOutput("no_upload_din", {16'h0, ioctl_din}, {16'h0, m_din});
        setUpload(1'b1);
        readHalf("refill_addr2", 25'h2, 4);

        // Timeout, sticky error, cleared by a new upload window
        readHalf("t4_timeout", 25'h20, 0);
        readHalf("t4_after_timeout", 25'h22, 2);
        setUpload(1'b0);
        setUpload(1'b1);
        @(negedge clk_sys);
        checkOutput("t4_err_cleared", {31'h0, rd_error}, 32'h0);

        // Upload drops mid-fetch with a late ack arriving during abort
        readHalf("t5_prefill", 25'h30, 1);
        ack_latency = 0;
        applyStimulus(1'b1, 25'h40);
        applyStimulus(1'b0, 25'h0);
        @(negedge clk_sys);
        ioctl_upload   = 1'b0;
        late_ack_delay = 1;
        @(negedge clk_sys);
        checkOutput("t5_cyc_drop", {31'h0, wb_cyc}, 32'h0);
        checkOutput("t5_wait_drop", {31'h0, ioctl_wait}, 32'h0);
        @(negedge clk_sys);
        checkOutput("t5_cyc_late_ack", {31'h0, wb_cyc}, 32'h0);
        checkOutput("t5_din_kept", {16'h0, ioctl_din}, {16'h0, m_din});
        checkOutput("t5_err_kept", {31'h0, rd_error}, {31'h0, m_err});
        setUpload(1'b1);
        readHalf("t5_reissue", 25'h40, 3);

        // Reset mid-fetch with the error flag set
        readHalf("t6_timeout", 25'h50, 0);
        ack_latency = 0;
        applyStimulus(1'b1, 25'h60);
        applyStimulus(1'b0, 25'h0);
        repeat (2) @(negedge clk_sys);
        checkOutput("t6_in_fetch", {31'h0, wb_cyc}, 32'h1);
        reset_n = 1'b0;
        @(negedge clk_sys);
        checkResetValues("t6_reset");
        reset_n = 1'b1;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_din   = 16'h0;
        @(negedge clk_sys);
        readHalf("t6_after_reset", 25'h60, 2);

        // Random reads over a small working set so hits and misses mix
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                addr = 25'($urandom);
            end else begin
                addr = {20'h0, 3'($urandom_range(0, 4)), 2'($urandom)};
            end
            if ($urandom_range(0, 11) == 0) begin
                setUpload(1'b0);
                setUpload(1'b1);
            end
            readHalf($sformatf("rnd%0d", n), addr, $urandom_range(1, 6));
            repeat ($urandom_range(0, 2)) @(negedge clk_sys);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
